// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared states, ASCII constants and digit helper for bin_to_ascii_bcd
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2,
        PRESENT = 2'd3
    } bcd_state_e;

    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  ASCII_DASH  = 8'h2D;
    localparam int unsigned MAX_DEC     = 999;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return {4'h0, digit} + ASCII_ZERO;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when a BCD digit is 5 or more
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // 4-bit add on purpose: no carry ever leaves the digit.
    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_ascii_bcd.sv
// rtl/bin_to_ascii_bcd.sv - sequential binary to three ASCII decimal digits with a data_ready/more_data handshake
module bin_to_ascii_bcd
    import bcd_pkg::*;
#(
    parameter int W     = 10,
    parameter bit BLANK = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] bin_i,
    output logic         ready_o,
    output logic [23:0]  data_o,
    output logic         data_ready_o,
    input  logic         more_data_i,
    output logic         overflow_o
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_CONVERT = CONVERT;
    localparam logic [1:0] ST_FORMAT  = FORMAT;
    localparam logic [1:0] ST_PRESENT = PRESENT;
    localparam logic [3:0] LAST_ITER  = 4'(W - 1);

    logic [1:0]   state;
    logic [3:0]   cnt;
    logic [W-1:0] shift_q;
    logic [11:0]  bcd_q;
    logic         ovf_q;
    logic [11:0]  bcd_adj;
    logic [7:0]   hund_a;
    logic [7:0]   tens_a;
    logic [7:0]   unit_a;
    logic [23:0]  fmt_data;

    bcd_digit_adj u_adj_hund (.d(bcd_q[11:8]), .q(bcd_adj[11:8]));
    bcd_digit_adj u_adj_tens (.d(bcd_q[7:4]),  .q(bcd_adj[7:4]));
    bcd_digit_adj u_adj_unit (.d(bcd_q[3:0]),  .q(bcd_adj[3:0]));

    always_comb begin
        hund_a = digit_to_ascii(bcd_q[11:8]);
        tens_a = digit_to_ascii(bcd_q[7:4]);
        unit_a = digit_to_ascii(bcd_q[3:0]);
        // Tens is only blanked when it is itself a leading zero.
        if (BLANK && (bcd_q[11:8] == 4'd0)) begin
            hund_a = ASCII_SPACE;
            if (bcd_q[7:4] == 4'd0) begin
                tens_a = ASCII_SPACE;
            end
        end
        fmt_data = ovf_q ? {ASCII_DASH, ASCII_DASH, ASCII_DASH} : {hund_a, tens_a, unit_a};
    end

    assign ready_o = (state == ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            shift_q      <= '0;
            bcd_q        <= 12'd0;
            ovf_q        <= 1'b0;
            data_o       <= 24'h000000;
            data_ready_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        shift_q <= bin_i;
                        bcd_q   <= 12'd0;
                        cnt     <= 4'd0;
                        ovf_q   <= (32'(bin_i) > MAX_DEC);
                        state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt              <= cnt + 4'd1;
                    if (cnt == LAST_ITER) begin
                        state <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    data_o     <= fmt_data;
                    overflow_o <= ovf_q;
                    state      <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    // data_ready_o rises one cycle into PRESENT, so a held more_data_i still sees every result.
                    if (!data_ready_o) begin
                        data_ready_o <= 1'b1;
                    end else if (more_data_i) begin
                        data_ready_o <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
